// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM,
// one-deep valid/ready output register with frame and overrun flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [15:0] LP_HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      r_state;
  logic        r_rx_meta;
  logic        r_rx_s;
  logic [15:0] r_cnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_busy;
  logic        r_frame_err;
  logic        r_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      if (r_rx_valid && rx_ready)
        r_rx_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            r_state <= START;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (r_cnt == LP_HALF) begin
            r_cnt <= '0;
            r_idx <= '0;
            if (r_rx_s) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= DATA;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DATA: begin
          if (r_cnt == LP_LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= r_rx_s;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7)
              r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        STOP: begin
          if (r_cnt == LP_LAST) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              // A same-cycle consume frees the slot for the new byte
              if (!r_rx_valid || rx_ready) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        WAIT_HIGH: begin
          if (r_rx_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
